// File: rtl/dram_wr_pkg.sv
// Shared types and default geometry for the 16-core DRAM word-line writer.
package dram_wr_pkg;

  localparam int CORES = 16;

  localparam int DEF_ROW_BITS = 64;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_WR_PULSE = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT_D,
    SHIFT_A,
    DVLD,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/dram_ser_phase.sv
// Serial slot phase counter: CLK_DIV low cycles then CLK_DIV high cycles per slot.
// hold freezes the counter (used to stretch the first low cycle during stalls).
module dram_ser_phase #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic level_en,
  output logic level,
  output logic slot_end
);

  localparam int SLOT = 2 * CLK_DIV;
  localparam int CW   = $clog2(SLOT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(CLK_DIV);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          level_reg;

  assign slot_end = en && !hold && (cnt_reg == CNT_LAST);
  assign level    = level_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (!en) begin
      cnt_next = '0;
    end else if (!hold) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Level is computed from the next count so the serial clock is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_en && (cnt_next >= CNT_HIGH);
    end
  end

endmodule

// File: rtl/dram_wbl_row_writer.sv
// Programs one word line into all 16 DRAM cores: serial data shift, serial row
// address shift, then DATA_VALID_IN and WRI_EN strobes.
module dram_wbl_row_writer
  import dram_wr_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int WR_PULSE = DEF_WR_PULSE
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic [CORES-1:0]  wdat,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  output logic              busy,
  output logic              done,
  output logic [CORES-1:0]  DIN,
  output logic              CLK_spw,
  output logic              CLRb_spw,
  output logic              ADD_IN,
  output logic              ADD_VALID_IN,
  output logic              DATA_VALID_IN,
  output logic              WRI_EN
);

  localparam int BW = $clog2(ROW_BITS + 1);
  localparam int AW = $clog2(ADDR_W + 1);
  localparam int WW = $clog2(WR_PULSE + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(ROW_BITS - 1);
  localparam logic [AW-1:0] ABIT_LAST = AW'(ADDR_W - 1);
  localparam logic [WW-1:0] WR_LAST   = WW'(WR_PULSE - 1);

  state_t            state_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic [AW-1:0]     abit_cnt_reg;
  logic [WW-1:0]     wr_cnt_reg;
  logic [ADDR_W-1:0] addr_sh_reg;
  logic [CORES-1:0]  din_reg;
  logic              wdat_ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              clrb_reg;
  logic              add_in_reg;
  logic              add_valid_reg;
  logic              data_valid_reg;
  logic              wri_en_reg;

  logic hs;
  logic ph_en;
  logic ph_hold;
  logic slot_end;
  logic spw_level;

  assign hs      = wdat_ready_reg && wdat_valid;
  assign ph_en   = (state_reg == SHIFT_D) || (state_reg == SHIFT_A);
  // A slot waiting for its word sits frozen in its first low cycle.
  assign ph_hold = (state_reg == SHIFT_D) && wdat_ready_reg && !wdat_valid;

  // One phase counter serves both the data bit slots and the address bit slots.
  dram_ser_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk      (CLK),
    .rst_n    (RSTn),
    .en       (ph_en),
    .hold     (ph_hold),
    .level_en (state_reg == SHIFT_D),
    .level    (spw_level),
    .slot_end (slot_end)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      abit_cnt_reg   <= '0;
      wr_cnt_reg     <= '0;
      addr_sh_reg    <= '0;
      din_reg        <= '0;
      wdat_ready_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      clrb_reg       <= 1'b1;
      add_in_reg     <= 1'b0;
      add_valid_reg  <= 1'b0;
      data_valid_reg <= 1'b0;
      wri_en_reg     <= 1'b0;
    end else begin
      if (hs) begin
        din_reg <= wdat;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= CLR;
            addr_sh_reg <= row_addr;
            busy_reg    <= 1'b1;
            clrb_reg    <= 1'b0;
          end
        end
        CLR: begin
          state_reg      <= SHIFT_D;
          clrb_reg       <= 1'b1;
          wdat_ready_reg <= 1'b1;
        end
        SHIFT_D: begin
          if (hs) begin
            wdat_ready_reg <= 1'b0;
          end
          if (slot_end) begin
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg   <= '0;
              state_reg     <= SHIFT_A;
              add_valid_reg <= 1'b1;
              add_in_reg    <= addr_sh_reg[ADDR_W-1];
              addr_sh_reg   <= addr_sh_reg << 1;
            end else begin
              bit_cnt_reg    <= bit_cnt_reg + 1'b1;
              wdat_ready_reg <= 1'b1;
            end
          end
        end
        SHIFT_A: begin
          if (slot_end) begin
            if (abit_cnt_reg == ABIT_LAST) begin
              abit_cnt_reg   <= '0;
              state_reg      <= DVLD;
              add_valid_reg  <= 1'b0;
              add_in_reg     <= 1'b0;
              data_valid_reg <= 1'b1;
            end else begin
              abit_cnt_reg <= abit_cnt_reg + 1'b1;
              add_in_reg   <= addr_sh_reg[ADDR_W-1];
              addr_sh_reg  <= addr_sh_reg << 1;
            end
          end
        end
        DVLD: begin
          state_reg      <= WRITE;
          data_valid_reg <= 1'b0;
          wri_en_reg     <= 1'b1;
          wr_cnt_reg     <= '0;
        end
        WRITE: begin
          if (wr_cnt_reg == WR_LAST) begin
            wr_cnt_reg <= '0;
            state_reg  <= DONE;
            wri_en_reg <= 1'b0;
            done_reg   <= 1'b1;
          end else begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wdat_ready    = wdat_ready_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign DIN           = din_reg;
  assign CLK_spw       = spw_level;
  assign CLRb_spw      = clrb_reg;
  assign ADD_IN        = add_in_reg;
  assign ADD_VALID_IN  = add_valid_reg;
  assign DATA_VALID_IN = data_valid_reg;
  assign WRI_EN        = wri_en_reg;

endmodule

// File: tb/tb_dram_wbl_row_writer.sv
// Bench for dram_wbl_row_writer: table-driven write scenarios, back-to-back
// starts and randomized stall patterns checked against a latency/sequence model.
module tb_dram_wbl_row_writer;
  import dram_wr_pkg::*;

  localparam int RB  = DEF_ROW_BITS;
  localparam int AW  = DEF_ADDR_W;
  localparam int CD  = DEF_CLK_DIV;
  localparam int WP  = DEF_WR_PULSE;
  localparam int LAT = 1 + 2 * CD * (RB + AW) + 1 + WP + 1;
  localparam logic [63:0] IDLE_VEC = 64'h10;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] row_addr = '0;
  logic [15:0]   wdat = '0;
  logic          wdat_valid = 1'b0;
  logic          wdat_ready, busy, done, CLK_spw, CLRb_spw;
  logic          ADD_IN, ADD_VALID_IN, DATA_VALID_IN, WRI_EN;
  logic [15:0]   DIN;

  dram_wbl_row_writer dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .start         (start),
    .row_addr      (row_addr),
    .wdat          (wdat),
    .wdat_valid    (wdat_valid),
    .wdat_ready    (wdat_ready),
    .busy          (busy),
    .done          (done),
    .DIN           (DIN),
    .CLK_spw       (CLK_spw),
    .CLRb_spw      (CLRb_spw),
    .ADD_IN        (ADD_IN),
    .ADD_VALID_IN  (ADD_VALID_IN),
    .DATA_VALID_IN (DATA_VALID_IN),
    .WRI_EN        (WRI_EN)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_word [RB];
  int          delay    [RB];

  typedef struct {
    logic [AW-1:0] addr;
    int            stall_at;
    int            stall_len;
    int            inj_at;
    logic [AW-1:0] inj_addr;
    int            reset_at;
    int            exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({wdat_ready, busy, done, DIN, CLK_spw, CLRb_spw,
                ADD_IN, ADD_VALID_IN, DATA_VALID_IN, WRI_EN});
  endfunction

  // One full write transaction; exp_word[] and delay[] describe data and stalls.
  task automatic run_write(input int id, input logic [AW-1:0] addr, input logic [AW-1:0] inj_addr,
                           input int inj_at, input int reset_at, input int exp_done);
    int k = 0, rises = 0, dvld = 0, wri = 0, ndone = 0, done_cyc = -1;
    int addr_cnt = 0, abits = 0, hold_bad = 0, word_bad = 0, clr_cnt = 0, busy_bad = 0;
    int wait_left, quiet_bad = 0;
    bit hs_pending = 1'b0, aborted = 1'b0;
    logic prev_spw = 1'b0;
    logic [15:0] prev_din = '0;
    logic [AW-1:0] got_addr = '0;

    wait_left = delay[0];
    @(negedge CLK);
    start = 1'b1;
    row_addr = addr;
    wdat = exp_word[0];
    wdat_valid = 1'b1;
    for (int cyc = 1; cyc <= LAT + 600; cyc++) begin
      @(negedge CLK);
      if (hs_pending) begin
        k++;
        wait_left = (k < RB) ? delay[k] : 0;
      end
      if (!CLRb_spw) clr_cnt++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== ((done_cyc < 0) || (cyc == done_cyc))) busy_bad++;
      if (!prev_spw && CLK_spw) begin
        if (rises < RB && (DIN !== exp_word[rises] || prev_din !== DIN)) word_bad++;
        rises++;
      end
      if (ADD_VALID_IN) begin
        if (addr_cnt % (2 * CD) == CD) begin
          got_addr = {got_addr[AW-2:0], ADD_IN};
          abits++;
        end
        addr_cnt++;
      end
      if (DATA_VALID_IN) dvld++;
      if (WRI_EN) wri++;
      prev_spw = CLK_spw;
      prev_din = DIN;

      if (reset_at >= 0 && k == reset_at) begin
        RSTn = 1'b0;
        #1;
        check("reset_mid_shift", out_vec(), IDLE_VEC);
        start = 1'b0;
        wdat_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int q = 0; q < 20; q++) begin
          @(negedge CLK);
          if (done || WRI_EN || busy || wdat_ready) quiet_bad++;
        end
        aborted = 1'b1;
        break;
      end

      start = (inj_at >= 0) && (k >= inj_at) && (k < inj_at + 3);
      row_addr = start ? inj_addr : addr;
      wdat = (k < RB) ? exp_word[k] : 16'hDEAD;
      if (wdat_ready && wait_left > 0) begin
        wdat_valid = 1'b0;
        wait_left--;
        if (k > 0 && (CLK_spw !== 1'b0 || DIN !== exp_word[k-1])) hold_bad++;
      end else begin
        wdat_valid = 1'b1;
      end
      hs_pending = wdat_valid && wdat_ready;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    wdat_valid = 1'b0;

    if (aborted) begin
      check("abort_quiet", quiet_bad, 0);
      check("abort_no_done", ndone, 0);
      check("abort_no_wri", wri, 0);
      $display("[TB] write %0d addr=%02h aborted by reset at word %0d", id, addr, k);
    end else begin
      check("done_cycle", done_cyc, exp_done);
      check("done_count", ndone, 1);
      check("spw_rises", rises, RB);
      check("words_accepted", k, RB);
      check("din_at_rise", word_bad, 0);
      check("stall_hold", hold_bad, 0);
      check("addr_bits", got_addr, addr);
      check("addr_slots", abits, AW);
      check("dvld_cycles", dvld, 1);
      check("wri_cycles", wri, WP);
      check("clr_cycles", clr_cnt, 1);
      check("busy_window", busy_bad, 0);
      $display("[TB] write %0d addr=%02h done at cycle %0d (expected %0d)", id, addr, done_cyc, exp_done);
    end
  endtask

  initial begin
    int first, second, clr2, exp_done;

    // Reset behaviour
    repeat (3) @(negedge CLK);
    check("in_reset", out_vec(), IDLE_VEC);
    RSTn = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_after_reset", out_vec(), IDLE_VEC);
    $display("[TB] reset and idle checked");

    //          addr   stall_at len inj_at inj_addr reset_at done
    vecs[0] = '{6'h2A, -1,      0,  -1,    6'h00,   -1,      287};
    vecs[1] = '{6'h2A, 20,      10, -1,    6'h00,   -1,      297};
    vecs[2] = '{6'h2A, -1,      0,  25,    6'h3F,   -1,      287};
    vecs[3] = '{6'h15, -1,      0,  -1,    6'h00,   30,      -1};
    vecs[4] = '{6'h01, -1,      0,  -1,    6'h00,   -1,      287};

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < RB; j++) begin
        exp_word[j] = 16'(j) ^ 16'hA5A5;
        delay[j] = 0;
      end
      if (vecs[i].stall_at >= 0) delay[vecs[i].stall_at] = vecs[i].stall_len;
      run_write(i, vecs[i].addr, vecs[i].inj_addr, vecs[i].inj_at, vecs[i].reset_at, vecs[i].exp_done);
      repeat (3) @(negedge CLK);
    end

    // start held high across two complete writes
    first = -1;
    second = -1;
    clr2 = -1;
    @(negedge CLK);
    start = 1'b1;
    row_addr = 6'h0A;
    wdat = 16'h1234;
    wdat_valid = 1'b1;
    for (int c = 1; c <= 2 * LAT + 50 && second < 0; c++) begin
      @(negedge CLK);
      if (done) begin
        if (first < 0) first = c;
        else second = c;
      end
      if (!CLRb_spw && first > 0 && clr2 < 0) clr2 = c;
    end
    start = 1'b0;
    wdat_valid = 1'b0;
    check("b2b_first_done", first, LAT);
    check("b2b_second_clr", clr2, first + 2);
    check("b2b_spacing", second - first, LAT + 1);
    $display("[TB] back-to-back dones at cycles %0d and %0d", first, second);
    repeat (3) @(negedge CLK);
    check("b2b_idle", {busy, done}, 2'b00);

    // Randomized words and stalls; each stall cycle adds one cycle of latency
    for (int r = 0; r < 4; r++) begin
      exp_done = LAT;
      for (int j = 0; j < RB; j++) begin
        exp_word[j] = 16'($urandom);
        delay[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
        exp_done += delay[j];
      end
      run_write(10 + r, AW'($urandom), 6'h00, -1, -1, exp_done);
      repeat (2) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
